msrv32_load_unit_seq: RTL

MSRV32_LOAD_UNIT_SEQ -- requirements
Module: msrv32_load_unit_seq

---
 rtl/msrv32_load_unit_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/msrv32_load_unit_seq.sv
// Sequential load unit: accepts one load, waits for bus data,
// then returns the lane-extracted, extended result for one cycle.
module msrv32_load_unit_seq #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic            ld_req_in,
  output logic            ld_ready_out,
  input  logic [1:0]      load_size_in,
  input  logic            load_unsigned_in,
  input  logic [2:0]      iadder_out_in,
  input  logic [XLEN-1:0] ms_riscv32_mp_dmdata_in,
  input  logic            ms_riscv32_mp_dmdata_valid_in,
  input  logic            ahb_resp_in,
  output logic [XLEN-1:0] lu_output_out,
  output logic            lu_valid_out,
  output logic            lu_misaligned_out,
  output logic            lu_fault_out
);

  localparam int LANE_W = (XLEN == 64) ? 3 : 2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [LANE_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic              mis_q, mis_d;
  logic              flt_q, flt_d;

  logic              req_mis;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   keep;
  logic              sbit;
  logic [XLEN-1:0]   ext;

  // Alignment decode of the incoming request
  always_comb begin
    req_mis = 1'b0;
    unique case (load_size_in)
      SZ_B: req_mis = 1'b0;
      SZ_H: req_mis = iadder_out_in[0];
      SZ_W: req_mis = (iadder_out_in[1:0] != 2'b00);
      SZ_D: req_mis = (XLEN == 32) || (iadder_out_in != 3'b000);
    endcase
  end

  // Lane extraction and sign/zero extension from captured fields
  always_comb begin
    shifted = ms_riscv32_mp_dmdata_in >> {addr_q, 3'b000};
    keep    = '1;
    sbit    = 1'b0;
    unique case (size_q)
      SZ_B: begin
        keep = XLEN'(8'hFF);
        sbit = shifted[7];
      end
      SZ_H: begin
        keep = XLEN'(16'hFFFF);
        sbit = shifted[15];
      end
      SZ_W: begin
        keep = XLEN'(32'hFFFF_FFFF);
        sbit = shifted[31];
      end
      SZ_D: begin
        keep = '1;
        sbit = 1'b0;
      end
    endcase
    ext = (shifted & keep)
        | (~keep & {XLEN{sbit & ~uns_q}});
  end

  // Next-state and result selection
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    mis_d   = mis_q;
    flt_d   = flt_q;
    unique case (state_q)
      IDLE: begin
        if (ld_req_in) begin
          size_d = load_size_in;
          uns_d  = load_unsigned_in;
          addr_d = iadder_out_in[LANE_W-1:0];
          if (req_mis) begin
            state_d = RESP;
            out_d   = '0;
            mis_d   = 1'b1;
            flt_d   = 1'b0;
          end else begin
            state_d = WAIT;
            cnt_d   = 8'd0;
          end
        end
      end
      WAIT: begin
        if (ms_riscv32_mp_dmdata_valid_in) begin
          state_d = RESP;
          mis_d   = 1'b0;
          flt_d   = ahb_resp_in;
          out_d   = ahb_resp_in ? '0 : ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          mis_d   = 1'b0;
          flt_d   = 1'b1;
          out_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q <= IDLE;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= 8'd0;
      out_q   <= '0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      mis_q   <= mis_d;
      flt_q   <= flt_d;
    end
  end

  assign ld_ready_out      = (state_q == IDLE);
  assign lu_valid_out      = (state_q == RESP);
  assign lu_output_out     = out_q;
  assign lu_misaligned_out = mis_q;
  assign lu_fault_out      = flt_q;

endmodule
